// File: rtl/audio_stream_player.sv
// audio_stream_player
//   Pulls packed 5-sample words from the sound FIFO and plays them through a
//   PWM speaker output at one sample every CLK_DIV clocks.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   EMPTY  | no word held; fetch when play_en=1 and the FIFO has data
//   FETCH  | reserved; never entered (the read strobe is issued from EMPTY)
//   WAIT   | read issued last cycle; capture fifo_dout this cycle
//   LOADED | word held; one sample is shifted out per sample_tick
//
// Ports
//   Clk          system clock (100 MHz), all state on rising edge
//   reset_rtl_0  asynchronous active-low reset
//   play_en      playback enable (level)
//   fifo_dout    FIFO read data, [24:0] = five samples, sample0 in [4:0]
//   fifo_empty   FIFO empty flag
//   fifo_rd_en   one-cycle FIFO read strobe (data arrives next cycle)
//   spk          registered PWM speaker drive
//   sample_out   sample currently being played
//   sample_tick  one-cycle pulse at each sample boundary
//   underrun     one-cycle pulse when a sample boundary finds no data
//   underrun_cnt saturating underrun count
module audio_stream_player #(
    parameter int CLK_DIV  = 2268,
    parameter int PWM_BITS = 5
) (
    input  logic                Clk,
    input  logic                reset_rtl_0,
    input  logic                play_en,
    input  logic [31:0]         fifo_dout,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    output logic                spk,
    output logic [PWM_BITS-1:0] sample_out,
    output logic                sample_tick,
    output logic                underrun,
    output logic [7:0]          underrun_cnt
);

    localparam int          SAMPLES   = 5;
    localparam int          WORD_BITS = SAMPLES * PWM_BITS;
    localparam logic [15:0] TICK_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] TICK_PRE  = 16'(CLK_DIV - 2);
    localparam logic [2:0]  SAMPLES_W = 3'(SAMPLES);

    typedef enum logic [1:0] {
        EMPTY,
        FETCH,
        WAIT,
        LOADED
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [15:0]            tick_cnt;
    logic [WORD_BITS-1:0]   shift;
    logic [2:0]             remaining;
    logic [PWM_BITS-1:0]    carrier;
    logic                   rd_req;
    logic                   capture;
    logic                   consume;
    logic                   unused_bits;

    assign unused_bits = ^fifo_dout[31:WORD_BITS];

    // sample_tick is registered one count early so it is high exactly while
    // tick_cnt sits at CLK_DIV-1, without a decode glitch on the output.
    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            tick_cnt    <= '0;
            sample_tick <= 1'b0;
        end else begin
            if (tick_cnt == TICK_LAST)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 16'd1;
            sample_tick <= (tick_cnt == TICK_PRE);
        end
    end

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        capture   = 1'b0;
        consume   = 1'b0;
        case (state)
            EMPTY: begin
                if (play_en && !fifo_empty) begin
                    rd_req    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // The read already happened, so finish it even if play_en fell.
                capture   = 1'b1;
                state_nxt = LOADED;
            end
            LOADED: begin
                if (sample_tick && play_en) begin
                    consume = 1'b1;
                    if (remaining == 3'd1)
                        state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // The state register is EMPTY while reset is held, which could otherwise
    // request a read; the FIFO must never see a strobe during reset.
    assign fifo_rd_en = rd_req & reset_rtl_0;

    // A tick that lands on the WAIT capture cycle is still an underrun: the
    // word is not playable until the following tick.
    assign underrun = sample_tick & play_en & (state != LOADED);

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            shift        <= '0;
            remaining    <= '0;
            sample_out   <= '0;
            underrun_cnt <= '0;
        end else begin
            if (capture) begin
                shift     <= fifo_dout[WORD_BITS-1:0];
                remaining <= SAMPLES_W;
            end else if (consume) begin
                shift     <= shift >> PWM_BITS;
                remaining <= remaining - 3'd1;
            end
            if (sample_tick)
                sample_out <= consume ? shift[PWM_BITS-1:0] : '0;
            if (underrun && (underrun_cnt != 8'hFF))
                underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

    // Free-running carrier; spk compares against the registered sample so a
    // new sample takes effect on the next carrier value.
    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            carrier <= '0;
            spk     <= 1'b0;
        end else begin
            carrier <= carrier + 1'b1;
            spk     <= (carrier < sample_out);
        end
    end

endmodule
